pipeline_hazard_unit: RTL
=========================

Name: pipeline_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the RV32I core pipeline. It decodes the instruction in IF/decode and tracks DEPTH downstream stages in a shift register of destination-register records. From those it produces operand forwarding selects, load-use stalls, redirect flushes and a global freeze on memory back-pressure. It generalises the fixed single-stage forwarding in the current controller to arbitrary pipeline depth and load latency.

Parameters:
DEPTH, 2, number of tracked stages after decode; entry 1 = execute, entry DEPTH = last write-back-capable stage; DEPTH >= LOAD_LAT+1
LOAD_LAT, 1, stages a load needs before its data can be forwarded; data is usable from entry LOAD_LAT+1
FLUSH_CYCLES, 1, decode slots killed per redirect; minimum 1
FW, $clog2(DEPTH+1), width of forwarding selects (derived; not user-set)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_inst  in  32  instruction in IF/decode
id_valid  in  1  id_inst is a real instruction
ex_redirect  in  1  taken branch/jump resolved in execute, single-cycle pulse
mem_busy  in  1  memory back-pressure; freezes the whole pipeline
stall_if  out  1  hold PC
stall_id  out  1  hold decode register
flush_id  out  1  kill decode instruction (becomes bubble)
fwd_a_sel  out  FW  rs1 source: 0 = regfile, k = entry k
fwd_b_sel  out  FW  rs2 source: 0 = regfile, k = entry k
stall_cycles  out  32  perf counter (see Optional Feature)
flush_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- Decode uses opcode id_inst[6:2]. Writes rd: LOAD(0), JALR(25), JAL(27), R(12), I(4), AUIPC(5), LUI(13). Uses rs1: LOAD, STORE(8), BRANCH(24), JALR, R, I, CSRW(28). Uses rs2: STORE, BRANCH, R. All other opcodes use and write nothing.
- Entry record: {valid, rd[4:0], wr, is_load}. An entry with rd==0 has wr=0; x0 is never forwarded.
- fwd_x_sel is combinational: the smallest k with entry k valid, wr and rd == rs_x, provided the instruction uses rs_x and id_valid=1; otherwise 0. Nearest stage wins.
- Load-use: a matching winning entry k with is_load and k <= LOAD_LAT asserts stall_if=stall_id=1. fwd selects are don't-care, driven 0.
- Each cycle, priority order:
  1. rst: all entries invalid; flush counter = 0; every output = 0.
  2. mem_busy: entries and flush counter hold; stall_if=stall_id=1; flush_id=0.
  3. ex_redirect, or flush counter != 0: flush_id=1; entry 1 <= bubble; entries shift; counter <= FLUSH_CYCLES-1 on a redirect, otherwise counter-1. A redirect while the counter is nonzero reloads the counter.
  4. Load-use: entry 1 <= bubble; entries shift; stall_if/stall_id high.
  5. Normal: entry 1 <= decoded id_inst (valid=id_valid); entry k <= entry k-1.
- Stalls caused by a load release automatically once the bubbles move the load to entry LOAD_LAT+1. No extra state is needed.
- The entry at DEPTH is discarded on shift.
- Latency: forwarding and stall outputs are zero-cycle, combinational from id_inst and registered entries. flush_id for a redirect is asserted in the same cycle as ex_redirect.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined: stall_cycles increments on every cycle with stall_id=1 and flush_cycles on every cycle with flush_id=1. Both counters are 32-bit wrapping, cleared by rst, and saturate at neither end.
- When undefined: both ports are driven constant 0 and no counter registers exist.

Test Plan:
- addi x5,x0,1 (0x00100293), then add x6,x5,x5 (0x00528333) -> fwd_a_sel=fwd_b_sel=1, stall_id=0.
- lw x5,0(x1) (0x0000a283), then add x6,x5,x0 with LOAD_LAT=1 -> stall_id=1 for exactly one cycle, bubble in entry 1, next cycle fwd_a_sel=2, fwd_b_sel=0.
- addi x0,x0,1, then add x6,x0,x0 -> fwd_a_sel=fwd_b_sel=0, no stall.
- FLUSH_CYCLES=2, ex_redirect one-cycle pulse -> flush_id high 2 consecutive cycles, two bubbles enter; mem_busy held during the 2nd cycle -> flush extends by the busy cycles.
- Load-use pending, then mem_busy for 3 cycles -> entries frozen, stall_if=1 throughout; after release, one further stall cycle, then fwd_a_sel=2.
- rst asserted during a flush (counter=1) -> next cycle flush_id=0, all selects 0, all entries invalid; with HAZARD_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_unit
// Purpose  : Operand forwarding, load-use stall, redirect flush and memory
//            freeze control over DEPTH tracked stages after decode.
//            Optional perf counters are built when HAZARD_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit #(
    parameter  int DEPTH        = 2,
    parameter  int LOAD_LAT     = 1,
    parameter  int FLUSH_CYCLES = 1,
    localparam int FW           = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   id_inst,
    input  logic          id_valid,
    input  logic          ex_redirect,
    input  logic          mem_busy,
    output logic          stall_if,
    output logic          stall_id,
    output logic          flush_id,
    output logic [FW-1:0] fwd_a_sel,
    output logic [FW-1:0] fwd_b_sel,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_cycles
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] c_reload = CW'(FLUSH_CYCLES - 1);

    localparam logic [4:0] c_op_load   = 5'd0;
    localparam logic [4:0] c_op_i      = 5'd4;
    localparam logic [4:0] c_op_auipc  = 5'd5;
    localparam logic [4:0] c_op_store  = 5'd8;
    localparam logic [4:0] c_op_r      = 5'd12;
    localparam logic [4:0] c_op_lui    = 5'd13;
    localparam logic [4:0] c_op_branch = 5'd24;
    localparam logic [4:0] c_op_jalr   = 5'd25;
    localparam logic [4:0] c_op_jal    = 5'd27;
    localparam logic [4:0] c_op_csrw   = 5'd28;

    // Stage records; index 1 is execute, index DEPTH is the oldest tracked.
    logic [DEPTH:1] valid_q, valid_d;
    logic [DEPTH:1] wr_q,    wr_d;
    logic [DEPTH:1] ld_q,    ld_d;
    logic [4:0]     rd_q [1:DEPTH];
    logic [4:0]     rd_d [1:DEPTH];
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [4:0] w_opc, w_rd, w_rs1, w_rs2;
    logic       w_writes, w_use_rs1, w_use_rs2, w_is_load;
    logic [FW-1:0] w_sel_a, w_sel_b;
    logic       w_ld_a, w_ld_b, w_load_use, w_flush_act;
    logic       w_unused;

    assign w_opc = id_inst[6:2];
    assign w_rd  = id_inst[11:7];
    assign w_rs1 = id_inst[19:15];
    assign w_rs2 = id_inst[24:20];
    assign w_unused = ^{id_inst[31:25], id_inst[14:12], id_inst[1:0]};

    always_comb begin
        w_writes  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opc)
            c_op_load, c_op_jalr, c_op_jal, c_op_r,
            c_op_i, c_op_auipc, c_op_lui: w_writes = 1'b1;
            default:                      w_writes = 1'b0;
        endcase
        case (w_opc)
            c_op_load, c_op_store, c_op_branch, c_op_jalr,
            c_op_r, c_op_i, c_op_csrw:    w_use_rs1 = 1'b1;
            default:                      w_use_rs1 = 1'b0;
        endcase
        case (w_opc)
            c_op_store, c_op_branch, c_op_r: w_use_rs2 = 1'b1;
            default:                         w_use_rs2 = 1'b0;
        endcase
    end

    assign w_is_load = (w_opc == c_op_load);

    // Walk from the oldest stage toward execute so the nearest match wins.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_valid && w_use_rs1 && valid_q[k] && wr_q[k] && (rd_q[k] == w_rs1)) begin
                w_sel_a = FW'(k);
                w_ld_a  = ld_q[k] && (k <= LOAD_LAT);
            end
            if (id_valid && w_use_rs2 && valid_q[k] && wr_q[k] && (rd_q[k] == w_rs2)) begin
                w_sel_b = FW'(k);
                w_ld_b  = ld_q[k] && (k <= LOAD_LAT);
            end
        end
    end

    assign w_load_use  = w_ld_a | w_ld_b;
    assign w_flush_act = ex_redirect | (cnt_q != '0);

    assign stall_if  = ~rst & (mem_busy | (~w_flush_act & w_load_use));
    assign stall_id  = stall_if;
    assign flush_id  = ~rst & ~mem_busy & w_flush_act;
    assign fwd_a_sel = (rst | w_load_use) ? '0 : w_sel_a;
    assign fwd_b_sel = (rst | w_load_use) ? '0 : w_sel_b;

    always_comb begin
        valid_d = valid_q;
        wr_d    = wr_q;
        ld_d    = ld_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (!mem_busy) begin
            for (int k = DEPTH; k >= 2; k--) begin
                valid_d[k] = valid_q[k-1];
                wr_d[k]    = wr_q[k-1];
                ld_d[k]    = ld_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            if (w_flush_act || w_load_use) begin
                valid_d[1] = 1'b0;
                wr_d[1]    = 1'b0;
                ld_d[1]    = 1'b0;
                rd_d[1]    = 5'd0;
            end else begin
                valid_d[1] = id_valid;
                wr_d[1]    = id_valid & w_writes & (w_rd != 5'd0);
                ld_d[1]    = id_valid & w_is_load;
                rd_d[1]    = w_rd;
            end
            if (ex_redirect) begin
                cnt_d = c_reload;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            wr_q    <= '0;
            ld_q    <= '0;
            cnt_q   <= '0;
            for (int k = 1; k <= DEPTH; k++) rd_q[k] <= 5'd0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
            for (int k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_id) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_id) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
